// File: rtl/forwarding_unit_pkg.sv
// -----------------------------------------------------------------------------
// forwarding_unit_pkg
// Purpose : Shared types and constants for the EX-stage operand forwarding
//           unit. It holds the MEM write-mode encoding, the R15 register index,
//           the data/register-number types and the forwarding-source enum.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package forwarding_unit_pkg;

  // 16-bit data word and 4-bit register number
  typedef logic [15:0] word_t;
  typedef logic [3:0]  regnum_t;

  // MEM-stage write mode (rWrite)
  localparam logic [1:0] RW_NONE = 2'd0;  // nothing written
  localparam logic [1:0] RW_ONE  = 2'd1;  // memop1 only
  localparam logic [1:0] RW_SWAP = 2'd2;  // memop1 and memop2
  localparam logic [1:0] RW_R15  = 2'd3;  // memop1 and R15 (mul high / div rem)

  // R15 is written implicitly by multiply/divide
  localparam regnum_t R15_IDX = 4'd15;

  // The MEM result that is forwarded to an operand
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_M1   = 2'd1,
    SRC_M2   = 2'd2,
    SRC_R15  = 2'd3
  } fwd_src_e;

endpackage : forwarding_unit_pkg

// File: rtl/forwarding_unit_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Purpose : Combinational forwarding selection for one EX operand. It picks
//           the MEM result that writes the operand's source register. Priority
//           is R15 result > memop1 result > memop2 result.
// Ports   : op          - source register number of the operand
//           memop1/2    - destination registers of the MEM instruction
//           memop1data  - result for memop1
//           memop2data  - result for memop2
//           memr15data  - result bound for R15
//           rwrite      - MEM write mode (RW_* encoding)
//           data_next   - selected data, zero when nothing is forwarded
//           fwd_next    - high when data_next is a valid forwarded value
// -----------------------------------------------------------------------------
module fwd_select
  import forwarding_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [3:0]  memop1,
  input  logic [3:0]  memop2,
  input  logic [15:0] memop1data,
  input  logic [15:0] memop2data,
  input  logic [15:0] memr15data,
  input  logic [1:0]  rwrite,
  output logic [15:0] data_next,
  output logic        fwd_next
);

  logic     hit_r15;
  logic     hit_m1;
  logic     hit_m2;
  fwd_src_e src;

  // Register 0 is an ordinary register here, so no zero-index suppression.
  // memop2 is only a real destination in swap mode; in the other modes a
  // match on it is ignored.
  assign hit_r15 = (rwrite == RW_R15) && (op == R15_IDX);
  assign hit_m1  = (rwrite != RW_NONE) && (op == memop1);
  assign hit_m2  = (rwrite == RW_SWAP) && (op == memop2);

  always_comb begin
    src = SRC_NONE;
    // The R15 hit wins even when memop1 is also 15. The implicit R15 write
    // carries the value the later instruction expects.
    if (hit_r15) begin
      src = SRC_R15;
    end else if (hit_m1) begin
      src = SRC_M1;
    end else if (hit_m2) begin
      src = SRC_M2;
    end
  end

  always_comb begin
    data_next = '0;
    fwd_next  = 1'b0;
    case (src)
      SRC_R15: begin
        data_next = memr15data;
        fwd_next  = 1'b1;
      end
      SRC_M1: begin
        data_next = memop1data;
        fwd_next  = 1'b1;
      end
      SRC_M2: begin
        data_next = memop2data;
        fwd_next  = 1'b1;
      end
      default: begin
        data_next = '0;
        fwd_next  = 1'b0;
      end
    endcase
  end

endmodule : fwd_select

// File: rtl/forwarding_unit.sv
// -----------------------------------------------------------------------------
// forwarding_unit
// Purpose : EX-stage operand forwarding from the MEM stage. Each of the two
//           operands (A, B) is resolved independently by a fwd_select
//           instance. The results are registered, so the outputs follow the
//           inputs with one cycle of latency.
// Ports   : clk         - rising-edge clock
//           rst_n       - synchronous active-low reset
//           op1, op2    - source registers of operand A / B
//           memop1/2    - destination registers of the MEM instruction
//           memop1data, memop2data, memr15data - MEM result data
//           rWrite      - MEM write mode (RW_NONE/RW_ONE/RW_SWAP/RW_R15)
//           fA, fB      - forwarded value for operand A / B (0 when none)
//           fwdA, fwdB  - high when fA / fB carries a forwarded value
// -----------------------------------------------------------------------------
module forwarding_unit
  import forwarding_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  op1,
  input  logic [3:0]  op2,
  input  logic [3:0]  memop1,
  input  logic [3:0]  memop2,
  input  logic [15:0] memop1data,
  input  logic [15:0] memop2data,
  input  logic [15:0] memr15data,
  input  logic [1:0]  rWrite,
  output logic [15:0] fA,
  output logic [15:0] fB,
  output logic        fwdA,
  output logic        fwdB
);

  localparam int NUM_OPS = 2;  // index 0 = operand A, index 1 = operand B

  regnum_t          op_arr    [NUM_OPS];
  word_t            data_next [NUM_OPS];
  logic [NUM_OPS-1:0] fwd_next;
  word_t            data_reg  [NUM_OPS];
  logic [NUM_OPS-1:0] fwd_reg;

  assign op_arr[0] = op1;
  assign op_arr[1] = op2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_sel
      fwd_select u_fwd_select (
        .op         (op_arr[gi]),
        .memop1     (memop1),
        .memop2     (memop2),
        .memop1data (memop1data),
        .memop2data (memop2data),
        .memr15data (memr15data),
        .rwrite     (rWrite),
        .data_next  (data_next[gi]),
        .fwd_next   (fwd_next[gi])
      );
    end
  endgenerate

  // Output registers. The reset clears them on the same edge. The first edge
  // after reset loads a normal selection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        data_reg[i] <= '0;
      end
      fwd_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        data_reg[i] <= data_next[i];
      end
      fwd_reg <= fwd_next;
    end
  end

  assign fA   = data_reg[0];
  assign fB   = data_reg[1];
  assign fwdA = fwd_reg[0];
  assign fwdB = fwd_reg[1];

endmodule : forwarding_unit

// File: tb/tb_forwarding_unit.sv
module tb_forwarding_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  op1, op2, memop1, memop2;
  logic [15:0] memop1data, memop2data, memr15data;
  logic [1:0]  rWrite;
  logic [15:0] fA, fB;
  logic        fwdA, fwdB;

  int errors = 0;
  int checks = 0;

  // Expected registered outputs (model state)
  logic [15:0] exp_fa, exp_fb;
  logic        exp_fwda, exp_fwdb;

  forwarding_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op1        (op1),
    .op2        (op2),
    .memop1     (memop1),
    .memop2     (memop2),
    .memop1data (memop1data),
    .memop2data (memop2data),
    .memr15data (memr15data),
    .rWrite     (rWrite),
    .fA         (fA),
    .fB         (fB),
    .fwdA       (fwdA),
    .fwdB       (fwdB)
  );

  always #5 clk = ~clk;

  // Reference: which MEM result writes register `op`, in priority order.
  function automatic logic [16:0] ref_fwd(input logic [3:0] op);
    if (rWrite == 2'd3 && op == 4'd15) return {1'b1, memr15data};
    if (rWrite != 2'd0 && op == memop1) return {1'b1, memop1data};
    if (rWrite == 2'd2 && op == memop2) return {1'b1, memop2data};
    return 17'h0;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fA"},   fA,           exp_fa);
    chk({tag, ".fB"},   fB,           exp_fb);
    chk({tag, ".fwdA"}, {15'h0, fwdA}, {15'h0, exp_fwda});
    chk({tag, ".fwdB"}, {15'h0, fwdB}, {15'h0, exp_fwdb});
    $display("step %-12s rst_n=%0d rW=%0d op1=%0d op2=%0d m1=%0d m2=%0d -> fA=%h fwdA=%0d fB=%h fwdB=%0d",
             tag, rst_n, rWrite, op1, op2, memop1, memop2, fA, fwdA, fB, fwdB);
  endtask

  // Clock one edge, update the model from the inputs sampled at that edge,
  // then compare 1 time unit after the edge.
  task automatic step(input string tag);
    logic [16:0] ra, rb;
    ra = ref_fwd(op1);
    rb = ref_fwd(op2);
    @(posedge clk);
    if (!rst_n) begin
      exp_fa = 16'h0; exp_fb = 16'h0; exp_fwda = 1'b0; exp_fwdb = 1'b0;
    end else begin
      {exp_fwda, exp_fa} = ra;
      {exp_fwdb, exp_fb} = rb;
    end
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic [1:0] rw, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] m1, input logic [3:0] m2);
    rWrite = rw; op1 = a; op2 = b; memop1 = m1; memop2 = m2;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(2'd3, 4'd15, 4'd15, 4'd15, 4'd15);
    memop1data = 16'hAAAA; memop2data = 16'hBBBB; memr15data = 16'hCCCC;
    #1;
    // Reset overrides hitting inputs
    step("reset0");
    step("reset1");

    // Reset and no-write; first post-reset edge loads a normal selection
    rst_n = 1'b1;
    set_in(2'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    step("nowrite");

    // Register 0 is ordinary
    set_in(2'd1, 4'd0, 4'd1, 4'd0, 4'd1);
    step("reg0");

    // Single write
    set_in(2'd1, 4'd5, 4'd6, 4'd5, 4'd6);
    step("one_hit");
    set_in(2'd1, 4'd6, 4'd6, 4'd5, 4'd6);
    step("one_m2ign");

    // Swap write
    set_in(2'd2, 4'd5, 4'd6, 4'd5, 4'd6);
    step("swap");
    set_in(2'd2, 4'd5, 4'd5, 4'd5, 4'd6);
    step("swap_same");

    // R15 write
    set_in(2'd3, 4'd15, 4'd6, 4'd5, 4'd6);
    step("r15");
    set_in(2'd2, 4'd15, 4'd6, 4'd5, 4'd6);
    step("swap_no15");

    // Priority
    set_in(2'd3, 4'd15, 4'd15, 4'd15, 4'd6);
    step("prio_r15");
    set_in(2'd2, 4'd3, 4'd7, 4'd7, 4'd7);
    step("prio_m1");

    // Latency: an input change before the edge leaves outputs unchanged
    set_in(2'd1, 4'd9, 4'd9, 4'd9, 4'd0);
    memop1data = 16'h1234;
    #2;
    check_all("hold");
    step("latency");

    // Mid-stream reset while fwdA=1
    rst_n = 1'b0;
    step("rst_mid");
    rst_n = 1'b1;
    step("post_rst");

    // Randomized traffic, biased toward register matches
    for (int n = 0; n < 300; n++) begin
      logic [3:0] m1, m2, a, b;
      m1 = 4'($urandom_range(0, 15));
      m2 = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: a = m1; 1: a = m2; 2: a = 4'd15; default: a = 4'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 3))
        0: b = m1; 1: b = m2; 2: b = 4'd15; default: b = 4'($urandom_range(0, 15));
      endcase
      set_in(2'($urandom_range(0, 3)), a, b, m1, m2);
      memop1data = 16'($urandom);
      memop2data = 16'($urandom);
      memr15data = 16'($urandom);
      rst_n = ($urandom_range(0, 15) != 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_forwarding_unit
